sfp_slf2std: RTL

SFP_SLF2STD -- requirements
Module: sfp_slf2std

---
 rtl/sfp_slf2std.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sfp_slf2std.sv
// ---------------------------------------------------------------------------
// sfp_slf2std
//   Converts a 26-bit "self" floating format word into an IEEE754 single.
//   Input word: [25] sign, [24:17] biased exponent e, [16:0] fraction.
//   The sign and fraction together form an 18-bit two's complement value S,
//   so the encoded value is S / 2^16 * 2^(max(e,1)-127).
//
//   Three-stage pipeline with a valid/ready handshake on both sides:
//     S1: capture input, magnitude M = |S|, effective exponent, zero flag
//     S2: leading-one position p, result exponent E = max(e,1) + p - 16
//     S3: normalise / denormalise by shifting, truncate, pack
//   Each stage loads when its successor is empty or advancing, so bubbles
//   collapse while the output is stalled.
//
//   Build option: define SFP_SLF2STD_SAT_EN to saturate overflows to the
//   largest finite magnitude; otherwise overflows produce infinity.
//
// Ports
//   i_clk  : clock, all state updates on the rising edge
//   i_rst  : synchronous active-high reset
//   i_req  : upstream presents a valid word on i_dat
//   i_dat  : 26-bit input word (self format)
//   o_rdy  : block accepts i_dat this cycle (i_req && o_rdy = accept)
//   o_vld  : o_dat holds a converted result
//   o_dat  : 32-bit IEEE754 single result
//   i_rdy  : downstream consumes o_dat this cycle (o_vld && i_rdy = leave)
// ---------------------------------------------------------------------------
module sfp_slf2std (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [25:0] i_dat,
  output logic        o_rdy,
  output logic        o_vld,
  output logic [31:0] o_dat,
  input  logic        i_rdy
);

  // Magnitude field used when the exponent overflows.
`ifdef SFP_SLF2STD_SAT_EN
  localparam logic [30:0] OVF_MAG = 31'h7F7FFFFF;
`else
  localparam logic [30:0] OVF_MAG = 31'h7F800000;
`endif

  // -------------------------------------------------------------------------
  // Handshake / stage enables
  // -------------------------------------------------------------------------
  logic [3:1] r_vld_pipe;
  logic       w_en1;
  logic       w_en2;
  logic       w_en3;

  // A stage may load when it is empty or its contents move on this cycle.
  assign w_en3 = !r_vld_pipe[3] || i_rdy;
  assign w_en2 = !r_vld_pipe[2] || w_en3;
  assign w_en1 = !r_vld_pipe[1] || w_en2;

  // Low only when every stage is full and the output is stalled; also held
  // low while reset is asserted.
  assign o_rdy = w_en1 && !i_rst;
  assign o_vld = r_vld_pipe[3];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_pipe <= '0;
    end else begin
      if (w_en1) r_vld_pipe[1] <= i_req;
      if (w_en2) r_vld_pipe[2] <= r_vld_pipe[1];
      if (w_en3) r_vld_pipe[3] <= r_vld_pipe[2];
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: capture, magnitude, effective exponent, zero detect
  // -------------------------------------------------------------------------
  logic [17:0] w_s;
  logic [17:0] w_m;
  logic [7:0]  w_eeff;
  logic        w_zero;

  assign w_s    = {i_dat[25], i_dat[16:0]};
  // -2^17 negates to itself, which read unsigned is exactly 2^17.
  assign w_m    = i_dat[25] ? (~w_s + 18'd1) : w_s;
  // e = 0 is the denormal encoding and scales like e = 1.
  assign w_eeff = (i_dat[24:17] == 8'd0) ? 8'd1 : i_dat[24:17];
  // e = 0 with an empty fraction is a signed zero even when sign = 1.
  assign w_zero = (w_m == 18'd0) ||
                  ((i_dat[24:17] == 8'd0) && (i_dat[16:0] == 17'd0));

  logic        r_s1_sign;
  logic [7:0]  r_s1_eeff;
  logic [17:0] r_s1_m;
  logic        r_s1_zero;

  always_ff @(posedge i_clk) begin
    if (w_en1 && i_req) begin
      r_s1_sign <= i_dat[25];
      r_s1_eeff <= w_eeff;
      r_s1_m    <= w_m;
      r_s1_zero <= w_zero;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: leading-one detect, result exponent
  // -------------------------------------------------------------------------
  logic [4:0] w_p;
  logic [9:0] w_e;

  // Highest set bit wins; M = 0 leaves p = 0 but is flagged zero anyway.
  always_comb begin
    w_p = 5'd0;
    for (int i = 0; i < 18; i++) begin
      if (r_s1_m[i]) w_p = 5'(i);
    end
  end

  // 10-bit two's complement: range is -15 .. 256.
  assign w_e = {2'b00, r_s1_eeff} + {5'b00000, w_p} - 10'd16;

  logic        r_s2_sign;
  logic [17:0] r_s2_m;
  logic [4:0]  r_s2_p;
  logic [9:0]  r_s2_e;
  logic        r_s2_zero;

  always_ff @(posedge i_clk) begin
    if (w_en2 && r_vld_pipe[1]) begin
      r_s2_sign <= r_s1_sign;
      r_s2_m    <= r_s1_m;
      r_s2_p    <= w_p;
      r_s2_e    <= w_e;
      r_s2_zero <= r_s1_zero;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3: normalise, denormalise, pack
  // -------------------------------------------------------------------------
  logic [23:0] w_sig;
  logic [9:0]  w_sh;
  logic [22:0] w_sub;
  logic [31:0] w_pack;

  // Leading one moved to bit 23; p <= 17 so the left shift is at least 6
  // and nothing falls off the top.
  assign w_sig = {6'b000000, r_s2_m} << (5'd23 - r_s2_p);

  // Denormal right shift (1 - E); only meaningful when E <= 0.
  assign w_sh  = 10'd1 - r_s2_e;

  always_comb begin
    w_sub = '0;
    if (w_sh < 10'd24) w_sub = 23'(w_sig >> w_sh[4:0]);
  end

  always_comb begin
    w_pack = {r_s2_sign, 31'd0};
    if (r_s2_zero)
      w_pack = {r_s2_sign, 31'd0};
    else if ($signed(r_s2_e) >= 10'sd255)
      w_pack = {r_s2_sign, OVF_MAG};
    else if ($signed(r_s2_e) >= 10'sd1)
      w_pack = {r_s2_sign, r_s2_e[7:0], w_sig[22:0]};
    else
      w_pack = {r_s2_sign, 8'd0, w_sub};
  end

  // Output register only changes when a new result moves in, so it stays
  // put while the downstream stalls.
  logic [31:0] r_out;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out <= '0;
    end else if (w_en3 && r_vld_pipe[2]) begin
      r_out <= w_pack;
    end
  end

  assign o_dat = r_out;

endmodule
